bounce_monitor: RTL and testbench

Receive-side checker for the up/down bounce counter's count stream. Each enabled cycle it samples a 16-bit count, recovers the counting direction, and detects turnarounds. It captures the peak and trough values, counts completed bounce periods, and flags stream violations against the programmed limits. It sits downstream of the counter, in the same clock domain, as a self-check and telemetry block.

---
 rtl/bounce_monitor.sv | 121 ++++++++++++
 tb/tb_bounce_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bounce_monitor.sv
// rtl/bounce_monitor.sv - receive-side checker for the up/down bounce counter's count stream
// Recovers direction, captures turnaround extremes, counts periods and flags stream violations.
module bounce_monitor #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         sample_en,
  input  logic [W-1:0] count_in,
  input  logic         load_seen,
  input  logic [W-1:0] upper_lim,
  input  logic [W-1:0] down_lim,
  input  logic         clr_err,
  output logic         locked,
  output logic         dir,
  output logic         turn_pulse,
  output logic [W-1:0] peak,
  output logic [W-1:0] trough,
  output logic [15:0]  cycle_cnt,
  output logic         err,
  output logic [1:0]   err_code
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_UP    = 2'd2;
  localparam logic [1:0] ST_DOWN  = 2'd3;

  localparam logic [1:0] CODE_STEP   = 2'b01;
  localparam logic [1:0] CODE_PEAK   = 2'b10;
  localparam logic [1:0] CODE_TROUGH = 2'b11;

  logic [1:0]   state;
  logic [W-1:0] prev;
  logic [W-1:0] delta;
  logic         step_inc;
  logic         step_dec;

  // Modulo subtraction makes the 0xFFFF<->0x0000 wrap a legal single step.
  assign delta    = count_in - prev;
  assign step_inc = (delta == W'(1));
  assign step_dec = (delta == {W{1'b1}});
  assign locked   = (state == ST_UP) || (state == ST_DOWN);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_EMPTY;
      prev       <= '0;
      dir        <= 1'b0;
      turn_pulse <= 1'b0;
      peak       <= '0;
      trough     <= '0;
      cycle_cnt  <= '0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      turn_pulse <= 1'b0;
      if (clr_err) begin
        err      <= 1'b0;
        err_code <= 2'b00;
      end
      // Violations below are assigned later so they override a coincident clear.
      if (sample_en) begin
        prev <= count_in;
        if (load_seen) begin
          state <= ST_SYNC;
        end else begin
          case (state)
            ST_EMPTY: state <= ST_SYNC;
            ST_SYNC: begin
              if (step_inc) begin
                state <= ST_UP;
                dir   <= 1'b0;
              end else if (step_dec) begin
                state <= ST_DOWN;
                dir   <= 1'b1;
              end else begin
                err      <= 1'b1;
                err_code <= CODE_STEP;
              end
            end
            ST_UP: begin
              if (step_dec) begin
                state      <= ST_DOWN;
                dir        <= 1'b1;
                peak       <= prev;
                turn_pulse <= 1'b1;
                if (prev < upper_lim) begin
                  err      <= 1'b1;
                  err_code <= CODE_PEAK;
                end
              end else if (!step_inc) begin
                state    <= ST_SYNC;
                err      <= 1'b1;
                err_code <= CODE_STEP;
              end
            end
            default: begin
              if (step_inc) begin
                state      <= ST_UP;
                dir        <= 1'b0;
                trough     <= prev;
                turn_pulse <= 1'b1;
                cycle_cnt  <= cycle_cnt + 16'd1;
                if (prev > down_lim) begin
                  err      <= 1'b1;
                  err_code <= CODE_TROUGH;
                end
              end else if (!step_dec) begin
                state    <= ST_SYNC;
                err      <= 1'b1;
                err_code <= CODE_STEP;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bounce_monitor.sv
// tb/tb_bounce_monitor.sv - scoreboard bench for bounce_monitor with a behavioural stream model
module tb_bounce_monitor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sample_en = 1'b0;
  logic [15:0] count_in = '0;
  logic        load_seen = 1'b0;
  logic [15:0] upper_lim = 16'd8;
  logic [15:0] down_lim = 16'd3;
  logic        clr_err = 1'b0;
  logic        locked, dir, turn_pulse, err;
  logic [15:0] peak, trough, cycle_cnt;
  logic [1:0]  err_code;

  bounce_monitor #(.W(16)) dut (
    .clk(clk), .rstn(rstn), .sample_en(sample_en), .count_in(count_in),
    .load_seen(load_seen), .upper_lim(upper_lim), .down_lim(down_lim),
    .clr_err(clr_err), .locked(locked), .dir(dir), .turn_pulse(turn_pulse),
    .peak(peak), .trough(trough), .cycle_cnt(cycle_cnt), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        locked;
    logic        dir;
    logic        pulse;
    logic [15:0] peak;
    logic [15:0] trough;
    logic [15:0] cyc;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model: history is "have a previous value" plus a signed direction (+1, -1, 0 = unknown).
  bit          m_have = 0;
  int          m_sdir = 0;
  logic [15:0] m_prev = '0;
  logic        m_dir_out = 0;
  logic        m_pulse = 0;
  logic [15:0] m_peak = '0, m_trough = '0, m_cyc = '0;
  logic        m_err = 0;
  logic [1:0]  m_code = '0;

  task automatic model_edge(input bit r, input bit en, input bit ld,
                            input logic [15:0] c, input bit clr);
    logic [15:0] d;
    int step;
    if (!r) begin
      m_have = 0; m_sdir = 0; m_prev = '0; m_dir_out = 0; m_pulse = 0;
      m_peak = '0; m_trough = '0; m_cyc = '0; m_err = 0; m_code = '0;
      return;
    end
    m_pulse = 0;
    if (clr) begin m_err = 0; m_code = 2'd0; end
    if (!en) return;
    d = c - m_prev;
    step = (d == 16'd1) ? 1 : (d == 16'hFFFF) ? -1 : 0;
    if (ld) begin
      m_have = 1; m_sdir = 0;
    end else if (!m_have) begin
      m_have = 1;
    end else if (m_sdir == 0) begin
      if (step != 0) begin m_sdir = step; m_dir_out = (step < 0); end
      else begin m_err = 1; m_code = 2'd1; end
    end else if (step == m_sdir) begin
      // continuing in the same direction
    end else if (step == -m_sdir) begin
      m_pulse = 1;
      if (m_sdir > 0) begin
        m_peak = m_prev;
        if (m_prev < upper_lim) begin m_err = 1; m_code = 2'd2; end
      end else begin
        m_trough = m_prev;
        m_cyc = m_cyc + 16'd1;
        if (m_prev > down_lim) begin m_err = 1; m_code = 2'd3; end
      end
      m_sdir = -m_sdir;
      m_dir_out = (m_sdir < 0);
    end else begin
      m_err = 1; m_code = 2'd1; m_sdir = 0;
    end
    m_prev = c;
  endtask

  task automatic drive(input bit r, input bit en, input bit ld,
                       input logic [15:0] c, input bit clr);
    exp_t e;
    @(negedge clk);
    rstn = r; sample_en = en; load_seen = ld; count_in = c; clr_err = clr;
    model_edge(r, en, ld, c, clr);
    e.locked = (m_sdir != 0); e.dir = m_dir_out; e.pulse = m_pulse;
    e.peak = m_peak; e.trough = m_trough; e.cyc = m_cyc;
    e.err = m_err; e.code = m_code;
    exp_q.push_back(e);
  endtask

  task automatic smp(input logic [15:0] c);
    drive(1, 1, 0, c, 0);
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 16'h0, 0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a registered result after every edge; compare it 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("locked", 16'(locked), 16'(e.locked));
        chk("dir", 16'(dir), 16'(e.dir));
        chk("turn_pulse", 16'(turn_pulse), 16'(e.pulse));
        chk("peak", peak, e.peak);
        chk("trough", trough, e.trough);
        chk("cycle_cnt", cycle_cnt, e.cyc);
        chk("err", 16'(err), 16'(e.err));
        chk("err_code", 16'(err_code), 16'(e.code));
      end
    end
  end

  initial begin
    logic [15:0] cur, top, bot;
    int gdir;
    upper_lim = 16'd8; down_lim = 16'd3;
    do_reset(); do_reset();
    // Lock
    smp(5); smp(6); smp(7);
    // Full bounce with a sample_en gap right after each turnaround
    do_reset();
    for (int v = 3; v <= 8; v++) smp(16'(v));
    smp(7); drive(1, 0, 0, 16'h7, 0);
    for (int v = 6; v >= 3; v--) smp(16'(v));
    smp(4); drive(1, 0, 0, 16'h4, 0);
    // Step error then relock
    do_reset();
    smp(5); smp(6); smp(9); smp(10); smp(11);
    // Short peak
    do_reset();
    smp(5); smp(6); smp(7); smp(6);
    // Resync via load, then clear the earlier error
    smp(5); smp(4);
    drive(1, 1, 1, 16'h0020, 0);
    smp(16'h001F);
    drive(1, 0, 0, 16'h0, 1);
    // Reset mid-bounce, wrap, clear coincident with step error
    smp(16'h1E); smp(16'h1D);
    do_reset();
    smp(16'hFFFE); smp(16'hFFFF); smp(16'h0000);
    drive(1, 1, 0, 16'h0005, 1);
    // Randomised bouncing stream with glitches, loads, gaps, clears and rare resets
    for (int seg = 0; seg < 6; seg++) begin
      down_lim  = 16'($urandom_range(100, 2000));
      upper_lim = down_lim + 16'($urandom_range(5, 40));
      cur = down_lim; gdir = 1;
      top = upper_lim; bot = down_lim;
      for (int i = 0; i < 400; i++) begin
        int p;
        p = $urandom_range(0, 999);
        if (p < 5) begin
          do_reset();
        end else if (p < 25) begin
          cur = 16'($urandom_range(int'(down_lim), int'(upper_lim)));
          drive(1, 1, 1, cur, 0);
        end else if (p < 150) begin
          drive(1, 0, $urandom_range(0, 1), 16'($urandom), $urandom_range(0, 3) == 0);
        end else begin
          if (p < 180) cur = cur + 16'($urandom_range(2, 9));
          else if (p < 190) cur = cur;
          else cur = (gdir > 0) ? cur + 16'd1 : cur - 16'd1;
          drive(1, 1, 0, cur, p < 200);
          if (gdir > 0 && cur >= top) begin
            gdir = -1; bot = down_lim + 16'($urandom_range(0, 2)) - 16'd1;
          end else if (gdir < 0 && cur <= bot) begin
            gdir = 1; top = upper_lim + 16'($urandom_range(0, 2)) - 16'd1;
          end
        end
      end
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
